// File: rtl/instr_fetch_queue_pkg.sv
// ============================================================================
// Module  : instr_fetch_queue_pkg
// Brief   : Shared types and default sizing for the fetch/decode queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fq_entry_t;

  localparam int FQ_DEPTH = 8;
  localparam int FQ_IN_W  = 2;
  localparam int FQ_OUT_W = 2;

  typedef logic [$clog2(FQ_DEPTH)-1:0] fq_ptr_t;
  typedef logic [$clog2(FQ_DEPTH+1)-1:0] fq_cnt_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_queue_bank.sv
// ============================================================================
// Module  : fq_bank
// Brief   : Register array with IN_W consecutive-address write ports and
//           OUT_W combinational read ports starting at a base address.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fq_bank
  import instr_fetch_queue_pkg::*;
#(
  parameter int DATA_W = $bits(fq_entry_t),
  parameter int DEPTH  = FQ_DEPTH,
  parameter int IN_W   = FQ_IN_W,
  parameter int OUT_W  = FQ_OUT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH)-1:0]       wr_addr,
  input  logic [$clog2(IN_W+1)-1:0]      wr_num,
  input  logic [IN_W*DATA_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0]       rd_addr,
  output logic [OUT_W*DATA_W-1:0]        rd_data
);

  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   w_waddr [IN_W];

  generate
    for (genvar i = 0; i < IN_W; i++) begin : g_waddr
      assign w_waddr[i] = wr_addr + c_AW'(i);
    end
    for (genvar i = 0; i < OUT_W; i++) begin : g_rd
      assign rd_data[i*DATA_W +: DATA_W] = r_mem[rd_addr + c_AW'(i)];
    end
  endgenerate

  // Lanes are packed from 0, so only the first wr_num lanes are written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < IN_W; i++) begin
        if (i < int'(wr_num)) r_mem[w_waddr[i]] <= wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module  : instr_fetch_queue
// Brief   : Multi-push / multi-pop in-order queue between fetch and decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DATA_W = $bits(fq_entry_t),
  parameter int DEPTH  = FQ_DEPTH,
  parameter int IN_W   = FQ_IN_W,
  parameter int OUT_W  = FQ_OUT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [$clog2(IN_W+1)-1:0]     in_num,
  input  logic [IN_W*DATA_W-1:0]        in_data,
  output logic                          in_ready,
  output logic [OUT_W-1:0]              out_valid,
  output logic [OUT_W*DATA_W-1:0]       out_data,
  input  logic [$clog2(OUT_W+1)-1:0]    out_num,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);
  localparam int c_IW = $clog2(IN_W+1);

  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  logic [c_IW-1:0] w_push_n;
  logic [c_CW-1:0] w_push_cnt;
  logic [c_CW-1:0] w_pop_cnt;
  logic            w_wr_en;

  // No pop look-ahead: a full-for-push queue rejects fetch even if decode pops.
  assign in_ready = (r_count <= c_CW'(DEPTH - IN_W));
  assign count    = r_count;

  always_comb begin
    w_push_n   = (in_num > c_IW'(IN_W)) ? c_IW'(IN_W) : in_num;
    w_push_cnt = '0;
    if (in_ready && !flush) w_push_cnt = c_CW'(w_push_n);
    w_pop_cnt  = (c_CW'(out_num) > r_count) ? r_count : c_CW'(out_num);
  end

  assign w_wr_en = in_ready && !flush && (w_push_n != '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_AW'(w_pop_cnt);
      r_tail  <= r_tail + c_AW'(w_push_cnt);
      r_count <= r_count + w_push_cnt - w_pop_cnt;
    end
  end

  generate
    for (genvar i = 0; i < OUT_W; i++) begin : g_valid
      assign out_valid[i] = (r_count > c_CW'(i));
    end
  endgenerate

  fq_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IN_W   (IN_W),
    .OUT_W  (OUT_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_addr (r_tail),
    .wr_num  (w_push_n),
    .wr_data (in_data),
    .rd_addr (r_head),
    .rd_data (out_data)
  );

endmodule

`default_nettype wire
